// File: rtl/next_symbol_unpacker.sv
// rtl/next_symbol_unpacker.sv - splits FIFO words into symbols for the Huffman dictionary
//
// Pops WORD_W-bit words from the input FIFO (one-cycle read latency), presents
// the WORD_W/SYM_W symbols of each word one at a time, paced by dict_ready.
// Signals sticky end-of-stream once the FIFO is empty and eof is set, and
// keeps a saturating count of emitted symbols.
//
// Ports:
//   clk        in   system clock, rising edge
//   n_rst      in   synchronous active-low reset
//   data       in   FIFO read data, valid the cycle after r_en
//   empty      in   FIFO empty flag
//   eof        in   source finished, no further words will be written
//   dict_ready in   dictionary accepts a symbol this cycle
//   r_en       out  FIFO read strobe, one pulse per word
//   char       out  current symbol, registered
//   c_en       out  symbol valid strobe, one pulse per symbol
//   done       out  end of stream, sticky until reset
//   sym_count  out  symbols emitted since reset, saturating

module next_symbol_unpacker #(
  parameter int WORD_W    = 32,
  parameter int SYM_W     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic [WORD_W-1:0] data,
  input  logic              empty,
  input  logic              eof,
  input  logic              dict_ready,
  output logic              r_en,
  output logic [SYM_W-1:0]  char,
  output logic              c_en,
  output logic              done,
  output logic [CNT_W-1:0]  sym_count
);

  localparam int N     = WORD_W / SYM_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LOAD,
    S_EMIT,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WORD_W-1:0] word;
  logic [IDX_W-1:0]  idx;
  logic [SYM_W-1:0]  sym_sel;
  logic              emit;

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus the state-decoded strobes. r_en and done come straight
  // from the state so they can never outlive READ/DONE by a cycle.
  always_comb begin
    state_nxt = state;
    r_en      = 1'b0;
    done      = 1'b0;
    emit      = 1'b0;
    case (state)
      S_IDLE: begin
        // A pending word wins over eof so nothing queued is ever dropped.
        if (!empty) begin
          state_nxt = S_READ;
        end else if (eof) begin
          state_nxt = S_DONE;
        end
      end
      S_READ: begin
        r_en      = 1'b1;
        state_nxt = S_LOAD;
      end
      S_LOAD: begin
        state_nxt = S_EMIT;
      end
      S_EMIT: begin
        if (dict_ready) begin
          emit = 1'b1;
          if (idx == LAST_IDX) begin
            // Skip IDLE when another word is waiting: N symbols per N+2 cycles.
            state_nxt = empty ? S_IDLE : S_READ;
          end
        end
      end
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Symbol picked by the current index; ordering within the word set by MSB_FIRST.
  always_comb begin
    sym_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (idx == IDX_W'(i)) begin
        if (MSB_FIRST) begin
          sym_sel = word[WORD_W-1-i*SYM_W -: SYM_W];
        end else begin
          sym_sel = word[i*SYM_W +: SYM_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      word      <= '0;
      idx       <= '0;
      char      <= '0;
      c_en      <= 1'b0;
      sym_count <= '0;
    end else begin
      c_en <= emit;
      // data is the FIFO output for the read issued in READ.
      if (state == S_LOAD) begin
        word <= data;
        idx  <= '0;
      end
      if (emit) begin
        char <= sym_sel;
        if (sym_count != {CNT_W{1'b1}}) begin
          sym_count <= sym_count + CNT_W'(1);
        end
        if (idx != LAST_IDX) begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_next_symbol_unpacker.sv
// tb/tb_next_symbol_unpacker.sv - self-checking bench for next_symbol_unpacker

module tb_next_symbol_unpacker;

  localparam int WORD_W = 32;
  localparam int SYM_W  = 8;
  localparam int N      = WORD_W / SYM_W;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              n_rst;
  logic [WORD_W-1:0] data;
  logic              empty;
  logic              eof;
  logic              dict_ready;

  logic              r_en_m, c_en_m, done_m;
  logic [SYM_W-1:0]  char_m;
  logic [CNT_W-1:0]  cnt_m;
  logic              r_en_l, c_en_l, done_l;
  logic [SYM_W-1:0]  char_l;
  logic [CNT_W-1:0]  cnt_l;

  always #5 clk = ~clk;

  next_symbol_unpacker #(.WORD_W(WORD_W), .SYM_W(SYM_W), .MSB_FIRST(1'b1), .CNT_W(CNT_W)) u_msb (
    .clk(clk), .n_rst(n_rst), .data(data), .empty(empty), .eof(eof), .dict_ready(dict_ready),
    .r_en(r_en_m), .char(char_m), .c_en(c_en_m), .done(done_m), .sym_count(cnt_m)
  );

  next_symbol_unpacker #(.WORD_W(WORD_W), .SYM_W(SYM_W), .MSB_FIRST(1'b0), .CNT_W(CNT_W)) u_lsb (
    .clk(clk), .n_rst(n_rst), .data(data), .empty(empty), .eof(eof), .dict_ready(dict_ready),
    .r_en(r_en_l), .char(char_l), .c_en(c_en_l), .done(done_l), .sym_count(cnt_l)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [WORD_W-1:0] fifo_q[$];
  logic [SYM_W-1:0]  exp_m[$];
  logic [SYM_W-1:0]  exp_l[$];
  int                exp_cnt_m, exp_cnt_l;
  logic [SYM_W-1:0]  last_m, last_l;
  bit                done_seen;
  bit                prev_ready;

  logic [SYM_W-1:0]  log_m[$];
  logic [SYM_W-1:0]  log_l[$];
  int                cen_cyc[$];
  int                ren_pulses = 0;
  int                done_cyc   = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: a word expands to its bytes, high byte first or low byte first.
  task automatic push_word(input logic [WORD_W-1:0] w);
    fifo_q.push_back(w);
    for (int i = 0; i < N; i++) begin
      exp_m.push_back(SYM_W'((w >> (SYM_W * (N - 1 - i))) & 32'hFF));
      exp_l.push_back(SYM_W'((w >> (SYM_W * i)) & 32'hFF));
    end
    empty = 1'b0;
  endtask

  task automatic model_reset();
    fifo_q.delete();
    exp_m.delete();
    exp_l.delete();
    exp_cnt_m = 0;
    exp_cnt_l = 0;
    last_m    = '0;
    last_l    = '0;
    done_seen = 0;
    empty     = 1'b1;
  endtask

  task automatic check_one(input bit d, input logic c, input logic [SYM_W-1:0] ch,
                           input logic [CNT_W-1:0] cnt);
    logic [SYM_W-1:0] e;
    int qsize;
    qsize = d ? exp_l.size() : exp_m.size();
    if (c) begin
      chk("c_en without dict_ready", {63'd0, prev_ready}, 64'd1);
      if (qsize == 0) begin
        chk("spurious c_en", {63'd0, c}, 64'd0);
      end else begin
        e = d ? exp_l.pop_front() : exp_m.pop_front();
        chk(d ? "char lsb" : "char msb", ch, e);
        if (d) begin
          if (exp_cnt_l < 65535) exp_cnt_l++;
        end else begin
          if (exp_cnt_m < 65535) exp_cnt_m++;
        end
      end
      if (d) last_l = ch; else last_m = ch;
    end else begin
      chk(d ? "char hold lsb" : "char hold msb", ch, d ? last_l : last_m);
    end
    chk(d ? "sym_count lsb" : "sym_count msb", cnt, d ? exp_cnt_l : exp_cnt_m);
  endtask

  // One clock: sample outputs at the falling edge, compare, then serve the FIFO.
  task automatic step();
    prev_ready = dict_ready;
    @(negedge clk);
    cyc++;
    if (!n_rst) begin
      chk("reset r_en", r_en_m, 0);
      chk("reset c_en", c_en_m, 0);
      chk("reset done", done_m, 0);
      chk("reset char", char_m, 0);
      chk("reset sym_count", cnt_m, 0);
      chk("reset c_en lsb", c_en_l, 0);
      model_reset();
    end else begin
      check_one(1'b0, c_en_m, char_m, cnt_m);
      check_one(1'b1, c_en_l, char_l, cnt_l);
      if (c_en_m) begin
        log_m.push_back(char_m);
        cen_cyc.push_back(cyc);
      end
      if (c_en_l) log_l.push_back(char_l);
      chk("r_en lsb vs msb", r_en_l, r_en_m);
      chk("done lsb vs msb", done_l, done_m);
      if (r_en_m) begin
        ren_pulses++;
        chk("r_en while empty", {63'd0, fifo_q.size() != 0}, 64'd1);
        if (fifo_q.size() > 0) data = fifo_q.pop_front();
        empty = (fifo_q.size() == 0);
      end
      if (done_m && !done_seen) begin
        done_seen = 1;
        done_cyc  = cyc;
        chk("done before drain", exp_m.size(), 0);
        chk("done without eof", eof, 1);
      end
      if (done_seen) begin
        chk("done sticky", done_m, 1);
        chk("r_en after done", r_en_m, 0);
      end
    end
  endtask

  task automatic clear_logs();
    log_m.delete();
    log_l.delete();
    cen_cyc.delete();
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    eof   = 1'b0;
    repeat (2) step();
    n_rst = 1'b1;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int ren0;
    int w;
    logic [31:0] bp_pat[7];
    logic [SYM_W-1:0] want;

    n_rst      = 1'b0;
    data       = '0;
    empty      = 1'b1;
    eof        = 1'b0;
    dict_ready = 1'b0;
    model_reset();
    repeat (3) step();
    n_rst      = 1'b1;
    dict_ready = 1'b1;
    step();
    chk("idle sym_count", cnt_m, 0);

    // Single word, both symbol orders, with exact latency.
    clear_logs();
    ren_pulses = 0;
    push_word(32'h41424344);
    k = cyc;
    repeat (10) step();
    chk("single n chars", log_m.size(), 4);
    chk("single msb c0", log_m[0], 8'h41);
    chk("single msb c1", log_m[1], 8'h42);
    chk("single msb c2", log_m[2], 8'h43);
    chk("single msb c3", log_m[3], 8'h44);
    chk("single lsb c0", log_l[0], 8'h44);
    chk("single lsb c3", log_l[3], 8'h41);
    chk("single first c_en cycle", cen_cyc[0], k + 4);
    chk("single last c_en cycle", cen_cyc[3], k + 7);
    chk("single r_en pulses", ren_pulses, 1);
    chk("single sym_count", cnt_m, 4);

    // Back-pressure pattern 1,0,0,1,1,0,1 once the word is loaded.
    clear_logs();
    bp_pat = '{1, 0, 0, 1, 1, 0, 1};
    push_word(32'h41424344);
    k = cyc;
    repeat (3) step();
    for (int i = 0; i < 7; i++) begin
      dict_ready = bp_pat[i][0];
      step();
    end
    dict_ready = 1'b1;
    repeat (5) step();
    chk("bp n pulses", cen_cyc.size(), 4);
    chk("bp pulse0", cen_cyc[0], k + 4);
    chk("bp pulse1", cen_cyc[1], k + 7);
    chk("bp pulse2", cen_cyc[2], k + 8);
    chk("bp pulse3", cen_cyc[3], k + 10);
    chk("bp sym_count", cnt_m, 8);

    // Back-to-back words.
    clear_logs();
    push_word(32'h01020304);
    push_word(32'h05060708);
    k = cyc;
    repeat (16) step();
    chk("b2b n chars", log_m.size(), 8);
    for (int i = 0; i < 8; i++) begin
      want = SYM_W'(i + 1);
      if (i < log_m.size()) chk("b2b char", log_m[i], want);
    end
    chk("b2b word1 end", cen_cyc[3], k + 7);
    chk("b2b word2 start", cen_cyc[4], k + 10);
    chk("b2b sym_count", cnt_m, 16);

    // End of stream: eof with a word still queued, then ignored input.
    clear_logs();
    push_word(32'hA0B0C0D0);
    eof = 1'b1;
    k   = cyc;
    repeat (12) step();
    chk("eos chars", log_m.size(), 4);
    chk("eos done cycle", done_cyc, k + 8);
    fifo_q.push_back(32'hDEADBEEF);
    empty = 1'b0;
    ren0  = ren_pulses;
    repeat (10) step();
    chk("eos no r_en after done", ren_pulses, ren0);
    chk("eos done held", done_m, 1);

    // Reset in the middle of a word discards the rest of it.
    do_reset();
    clear_logs();
    push_word(32'h55667788);
    repeat (5) step();
    chk("midword partial chars", log_m.size(), 2);
    n_rst = 1'b0;
    repeat (2) step();
    n_rst = 1'b1;
    clear_logs();
    ren0 = ren_pulses;
    repeat (10) step();
    chk("midword no stale chars", log_m.size(), 0);
    chk("midword no reads", ren_pulses, ren0);
    chk("midword sym_count", cnt_m, 0);

    // Randomised traffic against the model.
    for (int round = 0; round < 3; round++) begin
      do_reset();
      for (int i = 0; i < 300; i++) begin
        dict_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 3) == 0 && fifo_q.size() < 4) push_word($urandom);
        if (round == 1 && i == 150) begin
          n_rst = 1'b0;
          repeat (2) step();
          n_rst = 1'b1;
        end
        step();
      end
      eof        = 1'b1;
      dict_ready = 1'b1;
      w = 0;
      while (!done_seen && w < 300) begin
        step();
        w++;
      end
      chk("random done reached", {63'd0, done_seen}, 64'd1);
      chk("random drained", exp_m.size(), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
